// File: rtl/e17_out_capture.sv
// rtl/e17_out_capture.sv - change-only capture of the e17 output vector into a timestamped FIFO
//
// Samples y_in every posedge and, once capture is running, pushes a
// {timestamp, word} entry whenever the vector differs from the previous
// sample. A valid/ready consumer drains the first-word fall-through FIFO.
//
// Ports:
//   clk        clock; all state on posedge
//   rst        asynchronous reset, active-high
//   y_in       {y17..y1} from e17, bit0 = y1 (settled half a cycle before posedge)
//   en         capture enable
//   clr_ovf    synchronous clear of overflow and drop_cnt
//   out_valid  FIFO head entry valid
//   out_ready  consumer accepts the head entry
//   out_data   captured word at the FIFO head (last popped word when empty)
//   out_stamp  timestamp of the head entry (last popped stamp when empty)
//   level      FIFO occupancy 0..DEPTH
//   overflow   sticky: at least one change was dropped
//   drop_cnt   saturating count of dropped changes

module e17_out_capture #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] y_in,
    input  logic             en,
    input  logic             clr_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_stamp,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam int EW = CNT_W + WIDTH;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] tstamp_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [AW-1:0]    head_idx;

    // Capture FSM: PRIME loads prev without pushing so that enabling never
    // records the pre-existing vector as a change.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_PRIME;
            end
            S_PRIME: begin
                if (en) begin
                    prev_d  = y_in;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                prev_d = y_in;
                push   = en && (y_in != prev_q);
                if (!en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid = (level_q != '0);
    assign full      = (level_q == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_comb begin
        level_d = level_q + LW'(wr_en) - LW'(pop);
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // When empty, the slot just behind rd_ptr still holds the last popped
    // entry, so the outputs hold their last values without a separate register.
    assign head_idx  = out_valid ? rd_ptr_q : rd_ptr_q - AW'(1);
    assign out_data  = mem_q[head_idx][WIDTH-1:0];
    assign out_stamp = mem_q[head_idx][EW-1:WIDTH];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            tstamp_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            tstamp_q   <= tstamp_q + 1'b1;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {tstamp_q, y_in};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_e17_out_capture.sv
// tb/tb_e17_out_capture.sv - scoreboard bench for e17_out_capture

module tb_e17_out_capture;

    localparam int WIDTH = 17;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] y_in = '0;
    logic             en = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_stamp;
    logic [LW-1:0]    level;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    e17_out_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .y_in      (y_in),
        .en        (en),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_stamp (out_stamp),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [CNT_W-1:0] stamp;
        logic [WIDTH-1:0] data;
    } ent_t;

    // Reference model: expected FIFO contents plus occupancy and flags.
    ent_t             exp_q[$];
    ent_t             last_out = '0;
    int               en_run = 0;
    logic [WIDTH-1:0] y_last = '0;
    int               mlevel = 0;
    logic             movf = 1'b0;
    logic [CNT_W-1:0] mdrop = '0;
    logic [CNT_W-1:0] tcount = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture is live at an edge once en has been high for the two preceding
    // edges; a change is then measured against the vector seen at the last edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            last_out = '0;
            en_run   = 0;
            y_last   = '0;
            mlevel   = 0;
            movf     = 1'b0;
            mdrop    = '0;
            tcount   = '0;
        end else begin
            bit   m_pop, m_push, m_drop;
            ent_t e;
            m_pop  = (mlevel > 0) && out_ready;
            m_push = en && (en_run >= 2) && (y_in != y_last);
            m_drop = 1'b0;
            if (m_push) begin
                if (mlevel < DEPTH || m_pop) begin
                    e.stamp = tcount;
                    e.data  = y_in;
                    exp_q.push_back(e);
                    mlevel++;
                end else begin
                    m_drop = 1'b1;
                end
            end
            if (m_pop) mlevel--;
            if (clr_ovf) begin
                movf  = 1'b0;
                mdrop = '0;
            end else if (m_drop) begin
                movf = 1'b1;
                if (mdrop != {CNT_W{1'b1}}) mdrop++;
            end
            en_run = en ? ((en_run < 2) ? en_run + 1 : 2) : 0;
            y_last = y_in;
            tcount = tcount + 1'b1;
        end
    end

    // Monitor: compares the head against the scoreboard and retires it on handshake.
    always @(negedge clk) begin
        chk("out_valid", out_valid, mlevel != 0);
        chk("level", level, mlevel);
        chk("overflow", overflow, movf);
        chk("drop_cnt", drop_cnt, mdrop);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", 1, 0);
            end else begin
                chk("out_data", out_data, exp_q[0].data);
                chk("out_stamp", out_stamp, exp_q[0].stamp);
                if (out_ready) last_out = exp_q.pop_front();
            end
        end else begin
            chk("hold_data", out_data, last_out.data);
            chk("hold_stamp", out_stamp, last_out.stamp);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);

        // Enabling with a steady vector records nothing.
        en   = 1'b1;
        y_in = 17'h00144;
        repeat (5) cyc();
        chk("prime_level", level, 0);

        // First change lands at timestamp 5, visible one cycle later.
        y_in = 17'h00181;
        cyc();
        chk("first_valid", out_valid, 1);
        chk("first_data", out_data, 17'h00181);
        chk("first_stamp", out_stamp, 5);
        out_ready = 1'b1;
        repeat (2) cyc();
        out_ready = 1'b0;

        // Fill to DEPTH with the consumer stalled, then one more change drops.
        for (int i = 0; i < DEPTH; i++) begin
            y_in = y_in + 1'b1;
            cyc();
        end
        chk("full_level", level, DEPTH);
        y_in = y_in + 1'b1;
        cyc();
        chk("ovf_set", overflow, 1);
        chk("drop_one", drop_cnt, 1);

        // Change while full with a simultaneous pop: accepted, level unchanged.
        y_in      = 17'h1ABCD;
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("pushpop_level", level, DEPTH);
        chk("pushpop_drops", drop_cnt, 1);

        // Clear wins over a drop in the same cycle.
        y_in    = 17'h00001;
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_cnt", drop_cnt, 0);

        // Saturate the drop counter.
        for (int i = 0; i < (1 << CNT_W) + 20; i++) begin
            y_in = y_in ^ 17'h10001;
            cyc();
        end
        chk("drop_sat", drop_cnt, {CNT_W{1'b1}});

        // Drain: the word accepted during push+pop comes out last.
        out_ready = 1'b1;
        y_in      = y_in;
        repeat (DEPTH + 2) cyc();
        chk("drained", level, 0);
        chk("last_word", out_data, 17'h1ABCD);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;

        // Asynchronous reset with entries pending.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            y_in = y_in + 17'h00100;
            cyc();
        end
        chk("pre_rst_level", level, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_level", level, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        y_in = 17'h15555;
        repeat (4) cyc();
        chk("reprime_level", level, 0);

        // Randomized traffic, including enable gaps and reset pulses.
        for (int n = 0; n < 4000; n++) begin
            en        = ($urandom_range(0, 15) != 0);
            out_ready = ($urandom_range(0, 3) != 0) ? (n[9] | n[4]) : 1'b0;
            clr_ovf   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) == 0) y_in = WIDTH'($urandom);
            else if ($urandom_range(0, 3) == 0) y_in = y_in ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
            cyc();
        end

        en        = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 4) cyc();
        chk("final_level", level, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
